// File: rtl/rijndael_encrypt_core.sv
// rijndael_encrypt_core: iterative Rijndael encryption, one round per clock.
// Drives an external rijndael_keyschedule (key, reset, enable) and consumes
// its round keys.
//
// Ports:
//   clk_i, rst_ni              clock, async active-low reset
//   in_valid_i/in_ready_o      plaintext_i + key_i handshake
//   out_valid_o/out_ready_i    ciphertext_o handshake
//   ks_key_o, ks_rst_no        registered key and reset to the key schedule
//   ks_enable_o                steps the key schedule one round key
//   roundkey_i                 current round key from the key schedule
//
// Build option: RIJNDAEL_ZEROIZE_EN clears the state and key registers on
// the output handshake and masks ciphertext_o while out_valid_o is low.
module rijndael_encrypt_core #(
    parameter int NB = 4,
    parameter int NK = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [32*NB-1:0]     plaintext_i,
    input  logic [32*NK-1:0]     key_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [32*NB-1:0]     ciphertext_o,
    output logic [32*NK-1:0]     ks_key_o,
    output logic                 ks_rst_no,
    output logic                 ks_enable_o,
    input  logic [32*NB-1:0]     roundkey_i
);

    localparam int STATESIZE = 32 * NB;
    localparam int KEYSIZE   = 32 * NK;
    localparam int NR        = ((NB > NK) ? NB : NK) + 6;
    localparam int SH2       = (NB == 8) ? 3 : 2;
    localparam int SH3       = (NB == 8) ? 4 : 3;
    localparam logic [3:0] LAST_RND = 4'(NR - 1);

    // Entry x lives at bits [8*(255-x) +: 8].
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_INIT,
        S_ROUND,
        S_FINAL,
        S_DONE
    } fsm_e;

    fsm_e                 fsm_q, fsm_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [STATESIZE-1:0] state_q, state_d;
    logic [KEYSIZE-1:0]   ks_key_q, ks_key_d;
    logic                 ks_rst_n_q, ks_rst_n_d;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[8*(255-int'(x)) +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // SubBytes and ShiftRows fused: byte (c,r) takes the
    // substituted byte from column c+shift(r).
    function automatic logic [STATESIZE-1:0] sub_shift(
        input logic [STATESIZE-1:0] s
    );
        logic [STATESIZE-1:0] o;
        int sh;
        int src;
        o = '0;
        for (int c = 0; c < NB; c++) begin
            for (int r = 0; r < 4; r++) begin
                sh = (r == 0) ? 0 :
                     (r == 1) ? 1 :
                     (r == 2) ? SH2 : SH3;
                src = 4 * ((c + sh) % NB) + r;
                o[STATESIZE-1-8*(4*c+r) -: 8] =
                    sbox(s[STATESIZE-1-8*src -: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [STATESIZE-1:0] mix_columns(
        input logic [STATESIZE-1:0] s
    );
        logic [STATESIZE-1:0] o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < NB; c++) begin
            a0 = s[STATESIZE-1-32*c -: 8];
            a1 = s[STATESIZE-9-32*c -: 8];
            a2 = s[STATESIZE-17-32*c -: 8];
            a3 = s[STATESIZE-25-32*c -: 8];
            o[STATESIZE-1-32*c -: 32] = {
                xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)
            };
        end
        return o;
    endfunction

    always_comb begin
        fsm_d       = fsm_q;
        cnt_d       = cnt_q;
        state_d     = state_q;
        ks_key_d    = ks_key_q;
        ks_rst_n_d  = 1'b1;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        ks_enable_o = 1'b0;
        unique case (fsm_q)
            S_IDLE: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    state_d    = plaintext_i;
                    ks_key_d   = key_i;
                    // Low for exactly the LOAD cycle.
                    ks_rst_n_d = 1'b0;
                    fsm_d      = S_LOAD;
                end
            end
            S_LOAD: begin
                fsm_d = S_INIT;
            end
            S_INIT: begin
                state_d     = state_q ^ roundkey_i;
                ks_enable_o = 1'b1;
                cnt_d       = 4'd1;
                fsm_d       = S_ROUND;
            end
            S_ROUND: begin
                state_d = mix_columns(sub_shift(state_q))
                          ^ roundkey_i;
                ks_enable_o = 1'b1;
                cnt_d       = cnt_q + 4'd1;
                if (cnt_q == LAST_RND) begin
                    fsm_d = S_FINAL;
                end
            end
            S_FINAL: begin
                state_d = sub_shift(state_q) ^ roundkey_i;
                fsm_d   = S_DONE;
            end
            S_DONE: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    fsm_d = S_IDLE;
`ifdef RIJNDAEL_ZEROIZE_EN
                    state_d  = '0;
                    ks_key_d = '0;
`endif
                end
            end
            default: begin
                fsm_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fsm_q      <= S_IDLE;
            cnt_q      <= 4'd0;
            state_q    <= '0;
            ks_key_q   <= '0;
            ks_rst_n_q <= 1'b1;
        end else begin
            fsm_q      <= fsm_d;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            ks_key_q   <= ks_key_d;
            ks_rst_n_q <= ks_rst_n_d;
        end
    end

    assign ks_key_o  = ks_key_q;
    assign ks_rst_no = ks_rst_n_q;

`ifdef RIJNDAEL_ZEROIZE_EN
    assign ciphertext_o = out_valid_o ? state_q : '0;
`else
    assign ciphertext_o = state_q;
`endif

endmodule

// File: tb/tb_rijndael_encrypt_core.sv
// tb_rijndael_encrypt_core: three cores (NK=4,6,8, NB=4) on shared stimulus,
// each with a behavioural key schedule, checked against a Rijndael model.
module tb_rijndael_encrypt_core;

    localparam logic [127:0] PT1 =
        128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] KEY1 =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] KAT [3] = '{
        128'h69c4e0d86a7b0430d8cdb78070b4c55a,
        128'hdda97ca4864cdfe06eaf70a0ec0d7191,
        128'h8ea2b7ca516745bfeafc49904b496089
    };

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         out_ready;
    logic [127:0] pt;
    logic [255:0] key;
    logic [2:0]   ir, ov, ken, krn;
    logic [127:0] ct [3];
    logic [127:0] rk [3];
    logic [255:0] kso [3];

    int errors = 0;
    int checks = 0;

    bit           busy [3];
    bit           seen [3];
    bit           post [3];
    int           lat [3];
    int           kcnt [3];
    logic [127:0] expct [3];
    logic [255:0] expkey [3];

    always #5 clk = ~clk;

    // ---------------- behavioural Rijndael model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a,
                                        input logic [7:0] b);
        logic [8:0] x;
        logic [7:0] p;
        x = {1'b0, a};
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x[7:0];
            x = x << 1;
            if (x[8]) x = x ^ 9'h11b;
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254, then the affine map.
    function automatic logic [7:0] sbox_m(input logic [7:0] x);
        logic [7:0] r, sq, b;
        r = 8'h01;
        sq = x;
        for (int i = 1; i < 8; i++) begin
            sq = gmul(sq, sq);
            r = gmul(r, sq);
        end
        b = r;
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]}
                 ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox_m(w[31:24]), sbox_m(w[23:16]),
                sbox_m(w[15:8]), sbox_m(w[7:0])};
    endfunction

    // Round key idx from the top nk words of key.
    function automatic logic [127:0] roundkey_of(
        input logic [255:0] k, input int nk, input int idx
    );
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        int          i;
        rc = 8'h01;
        for (i = 0; i < nk; i++) w[i] = k[255-32*i -: 32];
        for (i = nk; i < 60; i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = subword(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        if (idx > 14) idx = 14;
        if (idx < 0) idx = 0;
        return {w[4*idx], w[4*idx+1], w[4*idx+2], w[4*idx+3]};
    endfunction

    function automatic logic [127:0] ref_encrypt(
        input logic [127:0] p, input logic [255:0] k, input int nk
    );
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] rkv;
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        int nr;
        nr = ((nk > 4) ? nk : 4) + 6;
        rkv = roundkey_of(k, nk, 0);
        for (int i = 0; i < 16; i++)
            s[i] = p[127-8*i -: 8] ^ rkv[127-8*i -: 8];
        for (int rd = 1; rd <= nr; rd++) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[4*c+r] = sbox_m(s[4*((c+r)%4)+r]);
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1];
                a2 = t[4*c+2]; a3 = t[4*c+3];
                if (rd < nr) begin
                    s[4*c]   = gmul(2, a0) ^ gmul(3, a1) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(2, a1) ^ gmul(3, a2) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(2, a2) ^ gmul(3, a3);
                    s[4*c+3] = gmul(3, a0) ^ a1 ^ a2 ^ gmul(2, a3);
                end else begin
                    s[4*c] = a0; s[4*c+1] = a1;
                    s[4*c+2] = a2; s[4*c+3] = a3;
                end
            end
            rkv = roundkey_of(k, nk, rd);
            for (int i = 0; i < 16; i++)
                s[i] = s[i] ^ rkv[127-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o;
    endfunction

    function automatic logic [255:0] key_mask(
        input logic [255:0] k, input int nk
    );
        return (k >> (256 - 32*nk)) << (256 - 32*nk);
    endfunction

    // ---------------- DUTs and key schedule models ----------------
    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int NKG = 4 + 2*g;
        logic [32*NKG-1:0] kso_w;
        logic              krn_w;
        int                ks_idx;

        rijndael_encrypt_core #(.NB(4), .NK(NKG)) u_dut (
            .clk_i        (clk),
            .rst_ni       (rst_n),
            .in_valid_i   (in_valid),
            .in_ready_o   (ir[g]),
            .plaintext_i  (pt),
            .key_i        (key[255 -: 32*NKG]),
            .out_valid_o  (ov[g]),
            .out_ready_i  (out_ready),
            .ciphertext_o (ct[g]),
            .ks_key_o     (kso_w),
            .ks_rst_no    (krn_w),
            .ks_enable_o  (ken[g]),
            .roundkey_i   (rk[g])
        );

        assign kso[g] = 256'(kso_w) << (256 - 32*NKG);
        assign krn[g] = krn_w;

        always @(posedge clk or negedge krn_w) begin
            if (!krn_w) ks_idx <= 0;
            else if (ken[g]) ks_idx <= ks_idx + 1;
        end

        assign rk[g] = roundkey_of(kso[g], NKG, ks_idx);
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input int g,
                       input logic [255:0] act,
                       input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0h want %0h",
                     name, g, act, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (!rst_n) begin
                busy[g] = 0;
                seen[g] = 0;
                post[g] = 0;
            end else begin
                if (post[g]) begin
                    chk("in_ready_after_hs", g, ir[g], 1);
                    chk("valid_after_hs", g, ov[g], 0);
`ifdef RIJNDAEL_ZEROIZE_EN
                    chk("ks_key_zeroized", g, kso[g], 0);
`else
                    chk("ct_kept", g, ct[g], expct[g]);
                    chk("ks_key_kept", g, kso[g], expkey[g]);
`endif
                    post[g] = 0;
                end
`ifdef RIJNDAEL_ZEROIZE_EN
                if (!ov[g]) chk("ct_masked", g, ct[g], 0);
`endif
                if (!busy[g]) chk("valid_when_idle", g, ov[g], 0);
                if (busy[g]) begin
                    lat[g]++;
                    if (!seen[g]) begin
                        if (ken[g]) kcnt[g]++;
                        chk("ks_rst_pulse", g, krn[g],
                            (lat[g] == 1) ? 0 : 1);
                    end
                    if (ov[g]) begin
                        if (!seen[g]) begin
                            chk("latency", g, lat[g], 4 + 2*g + 9);
                            chk("ks_enable_count", g, kcnt[g],
                                4 + 2*g + 6);
                            seen[g] = 1;
                        end
                        chk("ciphertext", g, ct[g], expct[g]);
                        chk("in_ready_in_done", g, ir[g], 0);
                        chk("ks_key", g, kso[g], expkey[g]);
                        if (out_ready) begin
                            busy[g] = 0;
                            seen[g] = 0;
                            post[g] = 1;
                        end
                    end
                end
                if (in_valid && ir[g]) begin
                    busy[g]   = 1;
                    seen[g]   = 0;
                    lat[g]    = 0;
                    kcnt[g]   = 0;
                    expct[g]  = ref_encrypt(pt, key, 4 + 2*g);
                    expkey[g] = key_mask(key, 4 + 2*g);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [255:0] rnd256();
        return {rnd128(), rnd128()};
    endfunction

    task automatic start_block(input logic [127:0] p,
                               input logic [255:0] k);
        in_valid = 1'b1;
        pt = p;
        key = k;
        @(posedge clk); #1;
        in_valid = 1'b0;
        pt = rnd128();
        key = rnd256();
    endtask

    task automatic wait_idle(input bit rnd);
        int t;
        t = 0;
        while ((busy[0] || busy[1] || busy[2]) && t < 400) begin
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            in_valid = (rnd && ir == 3'b000) ?
                       1'($urandom_range(0, 1)) : 1'b0;
            if (in_valid) begin
                pt = rnd128();
                key = rnd256();
            end
            @(posedge clk); #1;
            t++;
        end
        in_valid = 1'b0;
        if (t >= 400)
            chk("idle_timeout", 0, {busy[0], busy[1], busy[2]}, 0);
    endtask

    task automatic run_hold(input logic [127:0] p,
                            input logic [255:0] k,
                            input int hold, input bit lit);
        int t;
        out_ready = 1'b0;
        start_block(p, k);
        t = 0;
        while (ov != 3'b111 && t < 60) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 60) chk("valid_timeout", 0, ov, 3'b111);
        if (lit)
            for (int g = 0; g < 3; g++)
                chk("kat", g, ct[g], KAT[g]);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("in_ready_held", 0, ir, 3'b000);
            chk("valid_held", 0, ov, 3'b111);
        end
        out_ready = 1'b1;
        wait_idle(1'b0);
    endtask

    task automatic check_reset_values();
        for (int g = 0; g < 3; g++) begin
            chk("rst_out_valid", g, ov[g], 0);
            chk("rst_in_ready", g, ir[g], 1);
            chk("rst_ks_enable", g, ken[g], 0);
            chk("rst_ks_rst_n", g, krn[g], 1);
            chk("rst_ciphertext", g, ct[g], 0);
            chk("rst_ks_key", g, kso[g], 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        pt = '0;
        key = '0;
        #12;
        check_reset_values();
        #10;
        rst_n = 1'b1;
        @(posedge clk); #1;

        chk("model_sbox_00", 0, sbox_m(8'h00), 8'h63);
        chk("model_sbox_53", 0, sbox_m(8'h53), 8'hed);
        for (int g = 0; g < 3; g++)
            chk("model_kat", g, ref_encrypt(PT1, KEY1, 4 + 2*g),
                KAT[g]);

        run_hold(PT1, KEY1, 0, 1'b1);

        for (int i = 0; i < 10; i++) begin
            start_block(rnd128(), rnd256());
            wait_idle(1'b1);
        end
        out_ready = 1'b1;

        run_hold(rnd128(), rnd256(), 20, 1'b0);
        start_block(rnd128(), rnd256());
        wait_idle(1'b0);

        start_block(PT1, KEY1);
        repeat (6) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_hold(PT1, KEY1, 0, 1'b1);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
